// File: rtl/axi_timer.sv
// AXI4-Lite memory-mapped 32-bit timer with prescaler, compare match and level interrupt.
// Read and write channels run as independent FSMs; register writes commit on entry to WR_RESP.
module axi_timer #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  output logic        irq_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFFS_W = 3;
  localparam int unsigned STRB_W = 4;

  localparam logic [OFFS_W-1:0] A_CTRL   = 3'd0;
  localparam logic [OFFS_W-1:0] A_PRESC  = 3'd1;
  localparam logic [OFFS_W-1:0] A_COUNT  = 3'd2;
  localparam logic [OFFS_W-1:0] A_CMP    = 3'd3;
  localparam logic [OFFS_W-1:0] A_STATUS = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic               enable;
  logic               irq_en;
  logic               auto_reload;
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] presc_cnt;
  logic [DATA_W-1:0]  count;
  logic [DATA_W-1:0]  compare;
  logic               match;

  logic [OFFS_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [STRB_W-1:0]  wr_strb_q;

  logic               wr_commit_c;
  logic [OFFS_W-1:0]  wr_addr_c;
  logic [DATA_W-1:0]  wr_data_c;
  logic [STRB_W-1:0]  wr_strb_c;
  logic [DATA_W-1:0]  wr_merged_c;
  logic               tick_c;
  logic               hit_c;

  // Only offset bits [4:2] are decoded; the rest is intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr_i[31:5], araddr_i[1:0], awaddr_i[31:5], awaddr_i[1:0]};

  function automatic logic is_mapped(input logic [OFFS_W-1:0] a);
    return a <= A_STATUS;
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [OFFS_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    case (a)
      A_CTRL:   v = {29'd0, auto_reload, irq_en, enable};
      A_PRESC:  v = DATA_W'(prescale);
      A_COUNT:  v = count;
      A_CMP:    v = compare;
      A_STATUS: v = {31'd0, match};
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  // Select the address/data/strobe of the write completing this cycle, wherever each came from.
  always_comb begin
    wr_commit_c = 1'b0;
    wr_addr_c   = awaddr_i[4:2];
    wr_data_c   = wdata_i;
    wr_strb_c   = wstrb_i;
    case (wr_state)
      WR_IDLE:    wr_commit_c = awvalid_i && wvalid_i;
      WR_WAIT_W: begin
        wr_commit_c = wvalid_i;
        wr_addr_c   = wr_addr_q;
      end
      WR_WAIT_AW: begin
        wr_commit_c = awvalid_i;
        wr_data_c   = wr_data_q;
        wr_strb_c   = wr_strb_q;
      end
      default: wr_commit_c = 1'b0;
    endcase
    wr_merged_c = merge_bytes(read_reg(wr_addr_c), wr_data_c, wr_strb_c);
  end

  assign tick_c = enable && (presc_cnt == prescale);
  assign hit_c  = tick_c && (count == compare);
  assign irq_o  = match && irq_en;

  // Timer and register file; software writes are placed last so they override the tick update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      prescale    <= '0;
      presc_cnt   <= '0;
      count       <= '0;
      compare     <= '0;
      match       <= 1'b0;
    end else begin
      if (enable) presc_cnt <= tick_c ? '0 : presc_cnt + PRESC_W'(1);
      if (tick_c) count <= (hit_c && auto_reload) ? '0 : count + DATA_W'(1);
      if (hit_c) match <= 1'b1;
      if (wr_commit_c) begin
        case (wr_addr_c)
          A_CTRL: begin
            enable      <= wr_merged_c[0];
            irq_en      <= wr_merged_c[1];
            auto_reload <= wr_merged_c[2];
            if (!enable && wr_merged_c[0]) presc_cnt <= '0;
          end
          A_PRESC: begin
            prescale <= wr_merged_c[PRESC_W-1:0];
            if (|wr_strb_c) presc_cnt <= '0;
          end
          A_COUNT:  count   <= wr_merged_c;
          A_CMP:    compare <= wr_merged_c;
          A_STATUS: if (wr_strb_c[0] && wr_data_c[0] && !hit_c) match <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

  // Write channel FSM: accepts AW and W in either order, then holds B until bready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state  <= WR_IDLE;
      awready_o <= 1'b1;
      wready_o  <= 1'b1;
      bvalid_o  <= 1'b0;
      bresp_o   <= RESP_OKAY;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (awvalid_i && !wvalid_i) begin
            wr_addr_q <= awaddr_i[4:2];
            awready_o <= 1'b0;
            wr_state  <= WR_WAIT_W;
          end else if (wvalid_i && !awvalid_i) begin
            wr_data_q <= wdata_i;
            wr_strb_q <= wstrb_i;
            wready_o  <= 1'b0;
            wr_state  <= WR_WAIT_AW;
          end
        end
        WR_WAIT_W, WR_WAIT_AW: ;
        WR_RESP: begin
          if (bready_i) begin
            bvalid_o  <= 1'b0;
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
            wr_state  <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
      if (wr_commit_c) begin
        awready_o <= 1'b0;
        wready_o  <= 1'b0;
        bvalid_o  <= 1'b1;
        bresp_o   <= is_mapped(wr_addr_c) ? RESP_OKAY : RESP_SLVERR;
        wr_state  <= WR_RESP;
      end
    end
  end

  // Read channel FSM: data is captured at the AR handshake and held until rready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state  <= RD_IDLE;
      arready_o <= 1'b1;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (arvalid_i) begin
            rdata_o   <= read_reg(araddr_i[4:2]);
            rresp_o   <= is_mapped(araddr_i[4:2]) ? RESP_OKAY : RESP_SLVERR;
            arready_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rd_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready_i) begin
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rd_state  <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_timer.sv
// Directed bench for axi_timer: register-map vector table plus cycle-exact timer/handshake sequences.
module tb_axi_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int rd_cyc = 0;

  axi_timer #(.PRESC_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  // All transaction tasks start and end at a negative clock edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
    n = 0;
    while (!(awready && wready)) begin
      if (++n > 50) begin timeout("aw_w_ready"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; wr_cyc = cyc;
    n = 0;
    while (!bvalid) begin
      if (++n > 50) begin timeout("bvalid"); break; end
      @(negedge clk);
    end
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    arvalid = 1'b1; araddr = addr; rready = 1'b1;
    n = 0;
    while (!arready) begin
      if (++n > 50) begin timeout("arready"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    arvalid = 1'b0; rd_cyc = cyc;
    n = 0;
    while (!rvalid) begin
      if (++n > 50) begin timeout("rvalid"); break; end
      @(negedge clk);
    end
    data = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, 4'hF, r);
    check($sformatf("wr_resp@%02h", addr), 32'(r), 32'(2'b00));
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(name, d, exp);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int e;

    rst = 1'b1;
    arvalid = 0; araddr = 0; rready = 0;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Build some state, then reset asynchronously in the middle of a cycle.
    wr(32'h00, 32'h3);
    check("pre_reset_irq", 32'(irq), 32'd1);
    awvalid = 1'b1; awaddr = 32'h0C; arvalid = 1'b1; araddr = 32'h08; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    check("pre_reset_awready", 32'(awready), 32'd0);
    check("pre_reset_rvalid", 32'(rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", 32'({rresp, bresp}), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h0C, 32'h0000EE00, 4'h2, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 32'hAABBEEDD, 2'b00});
    vecs.push_back('{1'b0, 32'h18, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h1C, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h14, 32'h12345678, 4'hF, 32'h0, 2'b10});
    vecs.push_back('{1'b0, 32'h14, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h08, 32'hDEADBEEF, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h04, 32'h12345678, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'h00005678, 2'b00});
    vecs.push_back('{1'b1, 32'h00, 32'hFFFFFFF8, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h00, 32'h00000006, 4'h1, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 32'h00000006, 2'b00});
    vecs.push_back('{1'b1, 32'h00, 32'h0, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h04, 32'h0, 4'hF, 32'h0, 2'b00});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
      end
    end

    // AW three cycles ahead of W.
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0C;
    @(negedge clk); awvalid = 1'b0;
    check("aw_first_awready", 32'(awready), 32'd0);
    @(negedge clk);
    @(negedge clk); wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    check("aw_first_no_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk); wvalid = 1'b0;
    check("aw_first_bvalid", 32'(bvalid), 32'd1);
    check("aw_first_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    check("aw_first_bdone", 32'(bvalid), 32'd0);
    rd_check("aw_first_readback", 32'h0C, 32'h12345678);

    // W three cycles ahead of AW.
    wvalid = 1'b1; wdata = 32'h87654321; wstrb = 4'hF;
    @(negedge clk); wvalid = 1'b0;
    check("w_first_wready", 32'(wready), 32'd0);
    @(negedge clk);
    @(negedge clk); awvalid = 1'b1; awaddr = 32'h0C;
    check("w_first_no_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk); awvalid = 1'b0;
    check("w_first_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    rd_check("w_first_readback", 32'h0C, 32'h87654321);

    // Timer: tick every 4 cycles from the CTRL commit edge e; count after tick k is k mod 6.
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h5);
    wr(32'h04, 32'h3);
    wr(32'h10, 32'h1);
    wr(32'h00, 32'h7);
    e = wr_cyc;
    wait_cyc(e + 23);
    check("timer_irq_before_match", 32'(irq), 32'd0);
    @(negedge clk);
    check("timer_irq_at_match", 32'(irq), 32'd1);
    axi_read(32'h08, d, r);
    check("timer_count_reloaded", d, 32'(((rd_cyc - 1 - e) / 4) % 6));
    rd_check("timer_status_match", 32'h10, 32'h1);

    // W1C colliding with the next match (tick 12 at edge e+48): match must survive.
    wait_cyc(e + 47);
    wr(32'h10, 32'h1);
    check("w1c_vs_match_irq", 32'(irq), 32'd1);
    rd_check("w1c_vs_match_status", 32'h10, 32'h1);

    // W1C with no match pending: irq falls right after the commit edge.
    check("w1c_irq_before", 32'(irq), 32'd1);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h10; wdata = 32'h1; wstrb = 4'hF; bready = 1'b1;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    check("w1c_irq_after", 32'(irq), 32'd0);
    @(negedge clk); bready = 1'b0;
    wr(32'h00, 32'h0);

    // Stalled read with a concurrent COUNT write.
    wr(32'h08, 32'h00001111);
    arvalid = 1'b1; araddr = 32'h08; rready = 1'b0;
    @(negedge clk); arvalid = 1'b0;
    check("stall_rdata_0", rdata, 32'h00001111);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h08; wdata = 32'h00002222; wstrb = 4'hF; bready = 1'b1;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    check("stall_concurrent_bvalid", 32'(bvalid), 32'd1);
    check("stall_rdata_1", rdata, 32'h00001111);
    @(negedge clk); bready = 1'b0;
    check("stall_concurrent_bdone", 32'(bvalid), 32'd0);
    for (int i = 2; i < 5; i++) begin
      check($sformatf("stall_rdata_%0d", i), {rdata[31:1], rdata[0] & rvalid}, 32'h00001111);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk); rready = 1'b0;
    check("stall_rvalid_done", 32'(rvalid), 32'd0);
    rd_check("stall_count_written", 32'h08, 32'h00002222);

    // Wrap: tick 1 takes 0xFFFFFFFF to 0 without a match; tick 2 matches COMPARE=0.
    wr(32'h04, 32'h3);
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'hFFFFFFFF);
    wr(32'h00, 32'h3);
    e = wr_cyc;
    wait_cyc(e + 4);
    rd_check("wrap_count_zero", 32'h08, 32'h0);
    wait_cyc(e + 7);
    check("wrap_no_match", 32'(irq), 32'd0);
    @(negedge clk);
    check("wrap_match_at_zero", 32'(irq), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_timer.md
Name: axi_timer

Overview:
- AXI4-Lite slave peripheral: memory-mapped 32-bit timer with prescaler, compare match and interrupt.
- Sits directly downstream of the handshake-to-AXI bridge (through the interconnect) and consumes its AR/R/AW/W/B transactions.
- The interconnect decodes the base address; this block decodes only the offset bits.

Parameters:
- PRESC_W, 16, width of PRESCALE register and prescale counter (1..32).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- araddr_i  in  32  read address; only [4:2] used
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- rdata_o  out  32  read data
- rresp_o  out  2  read response
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- awaddr_i  in  32  write address; only [4:2] used
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- wdata_i  in  32  write data
- wstrb_i  in  4  byte strobes
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready
- bresp_o  out  2  write response
- irq_o  out  1  timer interrupt, level

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset: all registers, counters and FSMs go to 0/idle. arready_o=awready_o=wready_o=1; rvalid_o=bvalid_o=0; rdata_o=0; rresp_o=bresp_o=0; irq_o=0.
- Reset mid-transaction drops the transaction; no response is issued.
- Register map, offset addr[4:2]:
  - 0x00 CTRL: [0] enable, [1] irq_en, [2] auto_reload; other bits read 0.
  - 0x04 PRESCALE: [PRESC_W-1:0].
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: [0] match, write-1-to-clear.
  - 0x14..0x1C: unmapped. Reads return 0 with resp 2'b10 (SLVERR); writes are ignored with SLVERR.
  - Mapped accesses respond 2'b00 (OKAY).
- Byte strobes: a byte lane updates only if its wstrb bit is 1; wstrb=0 gives a no-op with OKAY. STATUS W1C uses wdata[0] only when wstrb[0]=1.
- Write FSM:
  - WR_IDLE: awready_o=1, wready_o=1.
    - AW and W both accepted in the same cycle -> WR_RESP.
    - AW only -> WR_WAIT_W, latch address, awready_o drops.
    - W only -> WR_WAIT_AW, latch data and strobe, wready_o drops.
  - WR_WAIT_W: wready_o=1; W handshake -> WR_RESP.
  - WR_WAIT_AW: awready_o=1; AW handshake -> WR_RESP.
  - The register update is committed on the clock edge entering WR_RESP.
  - WR_RESP: bvalid_o=1, bresp_o held stable until bready_i; then -> WR_IDLE.
  - Best-case latency: handshake cycle N, bvalid_o=1 at cycle N+1.
- Read FSM:
  - RD_IDLE: arready_o=1. On arvalid_i, rdata_o/rresp_o are registered from the current register values -> RD_DATA.
  - RD_DATA: arready_o=0, rvalid_o=1; rdata_o is stable until rready_i, then -> RD_IDLE.
  - Latency: AR handshake at cycle N, rvalid_o at N+1.
  - Read and write FSMs are independent and may run concurrently. A read returns the value from before any write committed in the same cycle.
- Timer:
  - When enable=1, presc_cnt increments each cycle. When presc_cnt==PRESCALE, presc_cnt returns to 0 and a tick occurs. PRESCALE=0 gives a tick every cycle.
  - On tick:
    - If COUNT==COMPARE: match<=1; COUNT<=0 if auto_reload, else COUNT+1.
    - Otherwise COUNT<=COUNT+1. Wraps 0xFFFFFFFF->0.
  - enable=0 freezes presc_cnt and COUNT.
  - A write to PRESCALE or CTRL.enable 0->1 clears presc_cnt.
- Simultaneous events:
  - Software write to COUNT overrides the tick update in the same cycle.
  - Hardware match set wins over W1C clear in the same cycle.
- irq_o = match & irq_en, combinational from flops; no added latency.

Test Plan:
- Reset asserted async mid-cycle -> all outputs at reset values immediately; readback of 0x00..0x10 returns 0/OKAY.
- AW at cycle 0, W at cycle 3 (and the reverse order) to 0x0C, data 0x12345678 -> bvalid_o at cycle 4, OKAY; read 0x0C returns 0x12345678.
- Write 0xAABBCCDD to COMPARE, then wstrb=4'b0010 data 0x0000EE00 -> COMPARE reads 0xAABBEEDD. Read 0x18 -> rdata_o 0, rresp_o 2'b10.
- PRESCALE=3, COMPARE=5, CTRL=0x7 -> COUNT increments every 4 cycles. At the tick with COUNT=5: match=1, irq_o=1 one cycle later, COUNT becomes 0.
- W1C STATUS=1 on the same cycle as a new match -> match stays 1. Write STATUS=1 again with no match -> irq_o falls the cycle after commit.
- rready_i held low 5 cycles, then COUNT write -> rdata_o stable throughout; concurrent write completes independently. COUNT=0xFFFFFFFF with COMPARE=0 and auto_reload=0 -> wraps to 0, no match until the next tick at 0.
